// File: rtl/io_pattern_pkg.sv
// Shared definitions for the pattern engine: the controller state encoding
// and the default sizing of the pin group, pattern table and error counter.
package io_pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/io_pattern_mem.sv
// Pattern table storage: DEPTH x WIDTH registers with a single synchronous
// write port and an asynchronous read port. Contents are not reset.
module io_pattern_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_pattern_engine.sv
// Pattern playback engine: loads a table of pin patterns, drives them one per
// cycle while comparing the captured pins, and reports mismatch statistics.
module io_pattern_engine
   import io_pattern_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     start,
   input  logic                     loop,
   input  logic                     abort,
   input  logic [WIDTH-1:0]         cap_in,
   output logic [WIDTH-1:0]         pat_out,
   output logic [WIDTH-1:0]         pat_oe,
   output logic                     busy,
   output logic                     done,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   len,
   output logic [CNT_W-1:0]         err_cnt,
   output logic                     err_seen,
   output logic [$clog2(DEPTH)-1:0] first_err_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   state_e           state_q, state_d;
   logic [LW-1:0]    len_q, len_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_seen_q, err_seen_d;
   logic [AW-1:0]    first_q, first_d;
   logic             mem_we;
   logic [WIDTH-1:0] rd_data;
   logic             full_w;
   logic             running;
   logic             last_entry;

   io_pattern_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk    (clk),
      .we_i   (mem_we),
      .waddr_i(len_q[AW-1:0]),
      .wdata_i(wr_data),
      .raddr_i(idx_q),
      .rdata_o(rd_data)
   );

   assign full_w     = (len_q == LW'(DEPTH));
   assign running    = (state_q == ST_RUN);
   assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));

   assign pat_out       = running ? rd_data : '0;
   assign pat_oe        = running ? '1 : '0;
   assign busy          = running;
   assign done          = (state_q == ST_DONE);
   assign full          = full_w;
   assign len           = len_q;
   assign err_cnt       = err_cnt_q;
   assign err_seen      = err_seen_q;
   assign first_err_idx = first_q;

   // With ena low nothing moves, which also stretches the done pulse.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      err_cnt_d  = err_cnt_q;
      err_seen_d = err_seen_q;
      first_d    = first_q;
      mem_we     = 1'b0;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               if (clr) begin
                  len_d = '0;
               end else if (wr_en && !full_w) begin
                  mem_we = 1'b1;
                  len_d  = len_q + LW'(1);
               end
               if (start) begin
                  idx_d      = '0;
                  err_cnt_d  = '0;
                  err_seen_d = 1'b0;
                  first_d    = '0;
                  state_d    = (len_q != '0) ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_d = ST_DONE;
               end else begin
                  if (cap_in != rd_data) begin
                     if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                     if (!err_seen_q) begin
                        err_seen_d = 1'b1;
                        first_d    = idx_q;
                     end
                  end
                  if (last_entry) begin
                     if (loop) idx_d = '0;
                     else      state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + AW'(1);
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         err_cnt_q  <= '0;
         err_seen_q <= 1'b0;
         first_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         err_cnt_q  <= err_cnt_d;
         err_seen_q <= err_seen_d;
         first_q    <= first_d;
      end
   end

endmodule

// File: tb/tb_io_pattern_engine.sv
// Directed bench for io_pattern_engine with a 2-bit error counter so that
// saturation is reachable in a handful of cycles.
module tb_io_pattern_engine;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic             clr;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic             loop;
   logic             abort;
   logic [WIDTH-1:0] cap_in;
   logic [WIDTH-1:0] pat_out;
   logic [WIDTH-1:0] pat_oe;
   logic             busy;
   logic             done;
   logic             full;
   logic [4:0]       len;
   logic [CNT_W-1:0] err_cnt;
   logic             err_seen;
   logic [3:0]       first_err_idx;

   int errors = 0;
   int checks = 0;
   logic [7:0] tbl [3];

   io_pattern_engine #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .clr          (clr),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .start        (start),
      .loop         (loop),
      .abort        (abort),
      .cap_in       (cap_in),
      .pat_out      (pat_out),
      .pat_oe       (pat_oe),
      .busy         (busy),
      .done         (done),
      .full         (full),
      .len          (len),
      .err_cnt      (err_cnt),
      .err_seen     (err_seen),
      .first_err_idx(first_err_idx)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_pat_out"}, 32'(pat_out), 32'h0);
      checkOutput({tag, "_pat_oe"},  32'(pat_oe),  32'h0);
      checkOutput({tag, "_busy"},    32'(busy),    32'h0);
      checkOutput({tag, "_done"},    32'(done),    32'h0);
   endtask

   initial begin
      tbl[0] = 8'h11;
      tbl[1] = 8'h22;
      tbl[2] = 8'h33;
      rst = 1'b1; ena = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0;
      start = 1'b0; loop = 1'b0; abort = 1'b0; cap_in = '0;
      #12;
      checkIdleOutputs("rst");
      checkOutput("rst_len",      32'(len),           32'd0);
      checkOutput("rst_full",     32'(full),          32'd0);
      checkOutput("rst_err_cnt",  32'(err_cnt),       32'd0);
      checkOutput("rst_err_seen", 32'(err_seen),      32'd0);
      checkOutput("rst_first",    32'(first_err_idx), 32'd0);
      rst = 1'b0;

      // Load 0x11, 0x22, 0x33
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = tbl[i];
         applyStimulus();
      end
      wr_en = 1'b0;
      checkOutput("load_len", 32'(len), 32'd3);

      // Clean playback with cap_in following the table
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("run1_oe",   32'(pat_oe), 32'hFF);
      checkOutput("run1_busy", 32'(busy),   32'd1);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("run1_pat%0d", k), 32'(pat_out), 32'(tbl[k]));
         checkOutput($sformatf("run1_done%0d", k), 32'(done), 32'd0);
         cap_in = tbl[k];
         applyStimulus();
      end
      checkOutput("run1_done",    32'(done),    32'd1);
      checkOutput("run1_busy_d",  32'(busy),    32'd0);
      checkOutput("run1_pat_d",   32'(pat_out), 32'h0);
      checkOutput("run1_oe_d",    32'(pat_oe),  32'h0);
      checkOutput("run1_err_cnt", 32'(err_cnt), 32'd0);
      applyStimulus();
      checkOutput("run1_done_once", 32'(done), 32'd0);

      // Fixed cap_in = 0x22: mismatches on entries 0 and 2
      cap_in = 8'h22;
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("run2_done",     32'(done),          32'd1);
      checkOutput("run2_err_cnt",  32'(err_cnt),       32'd2);
      checkOutput("run2_err_seen", 32'(err_seen),      32'd1);
      checkOutput("run2_first",    32'(first_err_idx), 32'd0);
      applyStimulus();

      // Looping: loop high for 7 compare edges then low
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         checkOutput($sformatf("loop_pat%0d", k), 32'(pat_out), 32'(tbl[k % 3]));
         loop = (k < 7);
         cap_in = tbl[k % 3];
         applyStimulus();
      end
      loop = 1'b0;
      checkOutput("loop_done",    32'(done),    32'd1);
      checkOutput("loop_err_cnt", 32'(err_cnt), 32'd0);
      applyStimulus();

      // Abort on the second entry; only entry 0's mismatch counts
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      cap_in = 8'h00;
      applyStimulus();
      checkOutput("abort_pat1", 32'(pat_out), 32'h22);
      abort = 1'b1; loop = 1'b1;
      applyStimulus();
      abort = 1'b0; loop = 1'b0;
      checkOutput("abort_done",    32'(done),          32'd1);
      checkOutput("abort_err_cnt", 32'(err_cnt),       32'd1);
      checkOutput("abort_first",   32'(first_err_idx), 32'd0);
      // Enable low stretches the done pulse
      ena = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("ena_done_hold", 32'(done), 32'd1);
      ena = 1'b1;
      applyStimulus();
      checkOutput("ena_done_end", 32'(done), 32'd0);

      // Enable low mid-run freezes playback and comparison
      cap_in = 8'hFF;
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      ena = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("ena_pat_hold",  32'(pat_out), 32'h11);
      checkOutput("ena_busy_hold", 32'(busy),    32'd1);
      checkOutput("ena_err_hold",  32'(err_cnt), 32'd0);
      ena = 1'b1;

      // Saturation: 5 mismatching compares on a looping run
      loop = 1'b1;
      repeat (5) applyStimulus();
      checkOutput("sat_err_cnt", 32'(err_cnt), 32'd3);
      checkOutput("sat_busy",    32'(busy),    32'd1);
      rst = 1'b1;
      #2;
      checkIdleOutputs("midrst");
      checkOutput("midrst_len",      32'(len),           32'd0);
      checkOutput("midrst_err_cnt",  32'(err_cnt),       32'd0);
      checkOutput("midrst_err_seen", 32'(err_seen),      32'd0);
      checkOutput("midrst_first",    32'(first_err_idx), 32'd0);
      rst = 1'b0; loop = 1'b0;
      applyStimulus();
      checkOutput("midrst_no_done", 32'(done), 32'd0);

      // Start with an empty table goes straight to done without driving
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("empty_done", 32'(done),   32'd1);
      checkOutput("empty_oe",   32'(pat_oe), 32'h0);
      applyStimulus();

      // 17 writes into a 16-entry table
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(i + 1);
         applyStimulus();
      end
      wr_en = 1'b0;
      checkOutput("full_flag", 32'(full), 32'd1);
      checkOutput("full_len",  32'(len),  32'd16);
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k == 0 || k == 15)
            checkOutput($sformatf("full_pat%0d", k), 32'(pat_out), 32'(k + 1));
         cap_in = 8'(k + 1);
         applyStimulus();
      end
      checkOutput("full_done",    32'(done),    32'd1);
      checkOutput("full_err_cnt", 32'(err_cnt), 32'd0);
      applyStimulus();

      // clr wins over wr_en in the same cycle
      clr = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
      applyStimulus();
      clr = 1'b0; wr_en = 1'b0;
      checkOutput("clr_len",  32'(len),  32'd0);
      checkOutput("clr_full", 32'(full), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_pattern_engine.md
IO_PATTERN_ENGINE -- requirements
Module: io_pattern_engine

Interface
REQ-001 Parameter WIDTH, default 8, pin-group width driven and captured.
REQ-002 Parameter DEPTH, default 16, pattern table entries; power of two, 2..256.
REQ-003 Parameter CNT_W, default 8, mismatch counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ena  input  1  enable; low freezes all state and outputs (no write, no advance, no compare).
REQ-007 clr  input  1  clear table length to 0 (IDLE only).
REQ-008 wr_en  input  1  append wr_data to table (IDLE only).
REQ-009 wr_data  input  WIDTH  pattern entry to append.
REQ-010 start  input  1  begin playback (IDLE only).
REQ-011 loop  input  1  sampled at end of table; high wraps playback to entry 0.
REQ-012 abort  input  1  end playback early.
REQ-013 cap_in  input  WIDTH  captured pin values, compared same cycle.
REQ-014 pat_out  output  WIDTH  current driven entry.
REQ-015 pat_oe  output  WIDTH  output enable, all-ones while playing, else zero.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse at end of run.
REQ-018 full  output  1  table holds DEPTH entries.
REQ-019 len  output  clog2(DEPTH)+1  entries loaded.
REQ-020 err_cnt  output  CNT_W  mismatch count, saturating.
REQ-021 err_seen  output  1  at least one mismatch this run.
REQ-022 first_err_idx  output  clog2(DEPTH)  entry index of first mismatch.

Function
REQ-023 States IDLE, RUN, DONE; DONE lasts exactly one cycle then IDLE.
REQ-024 IDLE: wr_en with len<DEPTH writes entry len, len+1; wr_en when full ignored, len unchanged.
REQ-025 clr has priority over wr_en same cycle; clr/wr_en ignored outside IDLE.
REQ-026 start in IDLE with len>0 at edge E0: RUN; err_cnt, err_seen, first_err_idx cleared; pat_out=entry 0, pat_oe all-ones after E0.
REQ-027 start with len==0: go to DONE directly, err_cnt=0, no pin driving.
REQ-028 RUN: at each edge, cap_in compared to pat_out; mismatch increments err_cnt (hold at 2^CNT_W-1); first mismatch latches index, sets err_seen.
REQ-029 After E_k pat_out=entry k; edge ending entry len-1: loop high -> pat_out=entry 0, continue; loop low -> DONE.
REQ-030 Entering DONE: pat_oe=0, pat_out=0, done=1 for that cycle; busy=0.
REQ-031 abort in RUN: that cycle's compare discarded, go to DONE; abort has priority over loop.
REQ-032 start in RUN or DONE ignored; table contents persist across runs until overwritten.
REQ-033 ena low in any state: hold everything; done pulse stretches while ena low.

Reset
REQ-034 rst high: state IDLE, len=0, pat_out=0, pat_oe=0, busy=0, done=0, err_cnt=0, err_seen=0, first_err_idx=0; table contents undefined.
REQ-035 rst mid-run aborts immediately with no done pulse.

Structure
REQ-036 Package io_pattern_pkg holds state enum and default parameter constants.
REQ-037 Sub-module io_pattern_mem: DEPTH x WIDTH register array, one write port, one combinational read port.

Verification
REQ-038 Load 0x11,0x22,0x33; start; cap_in=pat_out -> pat_out 11,22,33 on 3 cycles, done once, err_cnt=0.
REQ-039 Same table, cap_in=0x22 fixed -> err_cnt=2, err_seen=1, first_err_idx=0.
REQ-040 17 writes at DEPTH=16 -> full=1, len=16, 17th ignored.
REQ-041 loop high 7 cycles on 3-entry table then loop low -> sequence 11,22,33,11,22,33,11,22,33, done after 9th.
REQ-042 abort on 2nd entry -> done next cycle, err_cnt counts entry 0 only.
REQ-043 CNT_W=2, 5 mismatches -> err_cnt=3; rst mid-run -> all outputs reset values.
